// File: rtl/rv32_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: opcodes, FSM states
// and datapath mux/ALU select codes.
package rv32_ctrl_pkg;

  localparam int LAT_CNT_W = 4;

  localparam logic [6:0] R_TYPE = 7'b0110011;
  localparam logic [6:0] I_ALU  = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_EXEC_R    = 4'd2,
    S_EXEC_I    = 4'd3,
    S_LUI       = 4'd4,
    S_AUIPC     = 4'd5,
    S_WB_ALU    = 4'd6,
    S_MEM_ADDR  = 4'd7,
    S_MEM_RD    = 4'd8,
    S_WB_MEM    = 4'd9,
    S_MEM_WR    = 4'd10,
    S_BRANCH    = 4'd11,
    S_JAL       = 4'd12,
    S_EXEC_JALR = 4'd13,
    S_TRAP      = 4'd14
  } state_t;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_BRANCH = 2'b01;
  localparam logic [1:0] ALU_RTYPE  = 2'b10;
  localparam logic [1:0] ALU_ITYPE  = 2'b11;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MDR    = 2'b01;
  localparam logic [1:0] RES_PC     = 2'b10;

endpackage

// File: rtl/mem_wait_counter.sv
// Memory access-done generation: either the memory's ready strobe, or a
// fixed latency counted by a saturating counter that restarts at zero for
// every access.
module mem_wait_counter
  import rv32_ctrl_pkg::*;
#(
  parameter int MEM_HANDSHAKE = 1,
  parameter int MEM_LATENCY   = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic mem_ready,
  output logic done
);

  localparam logic [LAT_CNT_W-1:0] LAST = LAT_CNT_W'(MEM_LATENCY - 1);

  logic [LAT_CNT_W-1:0] cnt;

  // Count cycles spent in an access state; idle or completion returns to zero
  // so the next access (even back-to-back) starts fresh.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (!active || done) begin
      cnt <= '0;
    end else if (cnt != LAST) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign done = active && ((MEM_HANDSHAKE != 0) ? mem_ready : (cnt == LAST));

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM driving the shared-ALU datapath.
//
// state       | meaning
// ------------+-----------------------------------------------
// FETCH       | read instr at PC, PC <= PC+4 when access done
// DECODE      | ALUOut <= OldPC+imm, dispatch on opcode
// EXEC_R      | rs1 op rs2
// EXEC_I      | rs1 op imm
// LUI         | 0 + imm
// AUIPC       | OldPC + imm
// WB_ALU      | rd <= ALUOut
// MEM_ADDR    | ALUOut <= rs1 + imm
// MEM_RD      | read at ALUOut until access done
// WB_MEM      | rd <= MDR
// MEM_WR      | write at ALUOut until access done
// BRANCH      | compare, PC <= ALUOut if taken
// JAL         | rd <= PC, PC <= ALUOut
// EXEC_JALR   | rd <= PC, PC <= rs1+imm
// TRAP        | illegal opcode, parked until reset
module multicycle_controller
  import rv32_ctrl_pkg::*;
#(
  parameter int MEM_HANDSHAKE = 1,
  parameter int MEM_LATENCY   = 1,
  parameter int SUPPORT_JUMP  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] Opcode,
  input  logic       mem_ready,
  input  logic       branch_taken,
  output logic       IorD,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       PCSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic       illegal_instr,
  output logic [3:0] state_o
);

  state_t state_q, state_d;
  logic   illegal_q;
  logic   mem_access;
  logic   mem_done;

  assign mem_access = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);

  mem_wait_counter #(
    .MEM_HANDSHAKE(MEM_HANDSHAKE),
    .MEM_LATENCY  (MEM_LATENCY)
  ) u_wait (
    .clk      (clk),
    .reset    (reset),
    .active   (mem_access),
    .mem_ready(mem_ready),
    .done     (mem_done)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Sticky trap flag, set as the FSM enters TRAP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  illegal_q <= 1'b0;
    else if (state_d == S_TRAP) illegal_q <= 1'b1;
  end

  // Next-state and datapath controls; everything is forced low while reset is held.
  always_comb begin
    state_d   = state_q;
    IorD      = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    PCSrc     = 1'b0;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RS2;
    ALUOp     = ALU_ADD;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = RES_ALUOUT;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcA = SRCA_PC;
        ALUSrcB = SRCB_FOUR;
        if (mem_done) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (Opcode)
          R_TYPE:       state_d = S_EXEC_R;
          I_ALU:        state_d = S_EXEC_I;
          LOAD, STORE:  state_d = S_MEM_ADDR;
          BRANCH:       state_d = S_BRANCH;
          JAL:          state_d = (SUPPORT_JUMP != 0) ? S_JAL : S_TRAP;
          JALR:         state_d = (SUPPORT_JUMP != 0) ? S_EXEC_JALR : S_TRAP;
          LUI:          state_d = S_LUI;
          AUIPC:        state_d = S_AUIPC;
          default:      state_d = S_TRAP;
        endcase
      end
      S_EXEC_R: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_RS2;
        ALUOp   = ALU_RTYPE;
        state_d = S_WB_ALU;
      end
      S_EXEC_I: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALU_ITYPE;
        state_d = S_WB_ALU;
      end
      S_LUI: begin
        ALUSrcA = SRCA_ZERO;
        ALUSrcB = SRCB_IMM;
        state_d = S_WB_ALU;
      end
      S_AUIPC: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        state_d = S_WB_ALU;
      end
      S_WB_ALU: begin
        RegWrite  = 1'b1;
        ResultSrc = RES_ALUOUT;
        state_d   = S_FETCH;
      end
      S_MEM_ADDR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        state_d = (Opcode == LOAD) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
        if (mem_done) state_d = S_WB_MEM;
      end
      S_WB_MEM: begin
        RegWrite  = 1'b1;
        ResultSrc = RES_MDR;
        state_d   = S_FETCH;
      end
      S_MEM_WR: begin
        // MemWrite is held for the whole wait; the memory commits on its done cycle.
        IorD     = 1'b1;
        MemWrite = 1'b1;
        if (mem_done) state_d = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_RS2;
        ALUOp   = ALU_BRANCH;
        PCWrite = branch_taken;
        PCSrc   = 1'b1;
        state_d = S_FETCH;
      end
      S_JAL: begin
        RegWrite  = 1'b1;
        ResultSrc = RES_PC;
        PCWrite   = 1'b1;
        PCSrc     = 1'b1;
        state_d   = S_FETCH;
      end
      S_EXEC_JALR: begin
        // rd takes the already-incremented PC on the same edge PC takes rs1+imm.
        ALUSrcA   = SRCA_RS1;
        ALUSrcB   = SRCB_IMM;
        RegWrite  = 1'b1;
        ResultSrc = RES_PC;
        PCWrite   = 1'b1;
        state_d   = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase
    if (reset) begin
      IorD      = 1'b0;
      IRWrite   = 1'b0;
      PCWrite   = 1'b0;
      PCSrc     = 1'b0;
      ALUSrcA   = SRCA_PC;
      ALUSrcB   = SRCB_RS2;
      ALUOp     = ALU_ADD;
      MemRead   = 1'b0;
      MemWrite  = 1'b0;
      RegWrite  = 1'b0;
      ResultSrc = RES_ALUOUT;
    end
  end

  assign illegal_instr = illegal_q;
  assign state_o       = state_q;

endmodule
